// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
// Shared types and helpers for the FIFO write-port arbiter family.
//   arb_state_t : arbiter FSM encoding (IDLE, XFER)
//   idx_w       : width of a requester index (at least 1 bit)
//   cnt_w       : width of a beat counter that must hold 0..burst_max
//   rr_next     : circular search for the first set bit strictly after ptr
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Widest requester vector any arbiter in this family supports.
  localparam int MAX_REQ = 16;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_w(input int burst_max);
    return $clog2(burst_max + 1);
  endfunction

  // Returns the first index after ptr (wrapping at n) whose valid bit is set.
  // ptr itself is the last candidate, so a lone requester can be re-granted.
  // The result is 0 when nothing is valid; callers qualify it with |valid.
  function automatic logic [3:0] rr_next(input logic [MAX_REQ-1:0] valid,
                                         input logic [3:0] ptr,
                                         input int n);
    logic [3:0] res;
    logic       found;
    int         idx;
    res   = 4'd0;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % n;
      if ((i <= n) && !found && valid[idx]) begin
        res   = idx[3:0];
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// -----------------------------------------------------------------------------
// rr_picker
// Combinational round-robin search: finds the first valid requester strictly
// after the pointer, wrapping around.
// Ports:
//   valid [NREQ]  request vector
//   ptr   [IW]    last granted index (lowest priority in this search)
//   index [IW]    selected requester (0 when found is low)
//   found         at least one valid bit set
// -----------------------------------------------------------------------------
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [IW-1:0]   ptr,
  output logic [IW-1:0]   index,
  output logic            found
);

  assign found = |valid;
  assign index = IW'(rr_next(MAX_REQ'(valid), 4'(ptr), NREQ));

endmodule

// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
// Shares the async FIFO write port among NREQ requesters. Grants are
// round-robin and held for a whole packet (until last) or BURST_MAX beats, so
// packets are never interleaved. Writes are never issued while the FIFO is full.
// Optional statistics counters are built when FIFO_WR_ARB_STATS_EN is defined.
// Ports:
//   wclk, wrst             write-domain clock, async active-high reset
//   req_valid/data/last    per-requester beat stream (data i at [i*DSIZE +: DSIZE])
//   req_ready              beat accepted when valid & ready (only granted bit)
//   fifo_winc/wdata/wfull  FIFO write interface
//   grant_id               current / last granted requester
//   busy                   high while a grant is active (XFER)
//   stat_beats/stat_stall  (stats build) per-requester beats, stall cycles
//   stat_clr               (stats build) synchronous clear of all counters
// -----------------------------------------------------------------------------
module fifo_write_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DSIZE     = 8,
  parameter  int BURST_MAX = 4,
  localparam int IW        = idx_w(NREQ),
  localparam int CW        = cnt_w(BURST_MAX)
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic [NREQ-1:0]       req_last,
  output logic [NREQ-1:0]       req_ready,
  output logic                  fifo_winc,
  output logic [DSIZE-1:0]      fifo_wdata,
  input  logic                  fifo_wfull,
  output logic [IW-1:0]         grant_id,
  output logic                  busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*32-1:0]    stat_beats,
  output logic [31:0]           stat_stall,
  input  logic                  stat_clr
`endif
);

  localparam logic [CW-1:0] BURST_CNT = CW'(BURST_MAX);

  arb_state_t    state_r, state_nxt_s;
  logic [IW-1:0] grant_r, grant_nxt_s;
  logic [IW-1:0] ptr_r, ptr_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [IW-1:0] pick_idx_s;
  logic          pick_found_s;
  logic          accept_s;

  rr_picker #(.NREQ(NREQ)) u_picker (
    .valid (req_valid),
    .ptr   (ptr_r),
    .index (pick_idx_s),
    .found (pick_found_s)
  );

  assign accept_s   = (state_r == XFER) & req_valid[grant_r] & ~fifo_wfull;
  assign cnt_inc_s  = cnt_r + CW'(1'b1);
  assign fifo_wdata = req_data[int'(grant_r)*DSIZE +: DSIZE];
  assign grant_id   = grant_r;
  assign busy       = (state_r == XFER);

  // Arbiter state, grant, fairness pointer and beat counter.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_r <= IDLE;
      grant_r <= {IW{1'b0}};
      ptr_r   <= IW'(NREQ - 1);
      cnt_r   <= {CW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      ptr_r   <= ptr_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state logic and the combinational handshake toward requesters/FIFO.
  always_comb begin
    state_nxt_s = state_r;
    grant_nxt_s = grant_r;
    ptr_nxt_s   = ptr_r;
    cnt_nxt_s   = cnt_r;
    req_ready   = {NREQ{1'b0}};
    fifo_winc   = 1'b0;
    case (state_r)
      IDLE: begin
        // Arbitration cycle: no beat moves here, hence one bubble per grant.
        if (pick_found_s) begin
          grant_nxt_s = pick_idx_s;
          ptr_nxt_s   = pick_idx_s;
          cnt_nxt_s   = {CW{1'b0}};
          state_nxt_s = XFER;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      XFER: begin
        req_ready[grant_r] = ~fifo_wfull;
        fifo_winc          = accept_s;
        if (accept_s) begin
          cnt_nxt_s = cnt_inc_s;
          // last and the burst limit on the same beat release only once.
          if (req_last[grant_r] || (cnt_inc_s == BURST_CNT)) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = XFER;
          end
        end else if (!req_valid[grant_r] && (cnt_r == {CW{1'b0}})) begin
          // Requester withdrew before its first beat; give the port back.
          state_nxt_s = IDLE;
        end else begin
          // Mid-packet gaps and full-FIFO stalls keep the grant.
          state_nxt_s = XFER;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  localparam logic [31:0] STAT_SAT = 32'hFFFF_FFFF;

  logic [31:0] beats_r [NREQ];
  logic [31:0] stall_r;
  logic        stall_s;

  assign stall_s    = (state_r == XFER) & fifo_wfull & req_valid[grant_r];
  assign stat_stall = stall_r;

  for (genvar g = 0; g < NREQ; g++) begin : g_beats_out
    assign stat_beats[g*32 +: 32] = beats_r[g];
  end

  // Saturating statistics counters; clear wins over a same-cycle increment.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      for (int i = 0; i < NREQ; i++) beats_r[i] <= 32'd0;
      stall_r <= 32'd0;
    end else if (stat_clr) begin
      for (int i = 0; i < NREQ; i++) beats_r[i] <= 32'd0;
      stall_r <= 32'd0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (accept_s && (int'(grant_r) == i) && (beats_r[i] != STAT_SAT)) begin
          beats_r[i] <= beats_r[i] + 32'd1;
        end else begin
          beats_r[i] <= beats_r[i];
        end
      end
      if (stall_s && (stall_r != STAT_SAT)) begin
        stall_r <= stall_r + 32'd1;
      end else begin
        stall_r <= stall_r;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter (NREQ=4, DSIZE=8, BURST_MAX=4).
// Requester streams come from small per-requester beat tables; data bytes are
// {requester, beat} so the captured FIFO log shows grant order directly.
// Stats checks are compiled when FIFO_WR_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

  localparam int NREQ      = 4;
  localparam int DSIZE     = 8;
  localparam int BURST_MAX = 4;

  logic                  wclk = 1'b0;
  logic                  wrst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ*DSIZE-1:0] req_data = '0;
  logic [NREQ-1:0]       req_last = '0;
  logic [NREQ-1:0]       req_ready;
  logic                  fifo_winc;
  logic [DSIZE-1:0]      fifo_wdata;
  logic                  fifo_wfull = 1'b0;
  logic [1:0]            grant_id;
  logic                  busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ*32-1:0]    stat_beats;
  logic [31:0]           stat_stall;
  logic                  stat_clr = 1'b0;
`endif

  always #5 wclk = ~wclk;

  fifo_write_arbiter #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST_MAX(BURST_MAX)) dut (
    .wclk       (wclk),
    .wrst       (wrst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_winc  (fifo_winc),
    .fifo_wdata (fifo_wdata),
    .fifo_wfull (fifo_wfull),
    .grant_id   (grant_id),
    .busy       (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats (stat_beats),
    .stat_stall (stat_stall),
    .stat_clr   (stat_clr)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Requester beat tables: {last, data}
  logic [8:0]       src_mem [NREQ][16];
  int               src_head [NREQ];
  int               src_cnt [NREQ];
  logic [DSIZE-1:0] wlog [$];
  int               cyc;
  int               last_wr_cyc;
  logic [NREQ-1:0]  acc, rdy;
  logic             win, bsy;
  logic [DSIZE-1:0] wd;
  logic [4:0]       wtrace, btrace;

  task automatic add_beat(input int r, input logic [7:0] d, input logic l);
    src_mem[r][src_cnt[r]] = {l, d};
    src_cnt[r]++;
  endtask

  task automatic refresh();
    for (int i = 0; i < NREQ; i++) begin
      if (src_head[i] < src_cnt[i]) begin
        req_valid[i]                = 1'b1;
        req_data[i*DSIZE +: DSIZE]  = src_mem[i][src_head[i]][7:0];
        req_last[i]                 = src_mem[i][src_head[i]][8];
      end else begin
        req_valid[i]                = 1'b0;
        req_data[i*DSIZE +: DSIZE]  = 8'h00;
        req_last[i]                 = 1'b0;
      end
    end
  endtask

  // One clock: sample outputs at the falling edge, then advance sources and
  // the FIFO log just after the rising edge.
  task automatic tick();
    @(negedge wclk);
    acc = req_valid & req_ready;
    rdy = req_ready;
    win = fifo_winc;
    bsy = busy;
    wd  = fifo_wdata;
    @(posedge wclk);
    #1;
    cyc++;
    if (win) begin
      wlog.push_back(wd);
      last_wr_cyc = cyc;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) src_head[i]++;
    end
    refresh();
  endtask

  task automatic do_reset();
    wrst       = 1'b1;
    fifo_wfull = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    stat_clr   = 1'b0;
`endif
    for (int i = 0; i < NREQ; i++) begin
      src_head[i] = 0;
      src_cnt[i]  = 0;
    end
    wlog.delete();
    refresh();
    @(posedge wclk);
    #1;
    check("rst_busy",  {63'd0, busy}, 64'd0);
    check("rst_winc",  {63'd0, fifo_winc}, 64'd0);
    check("rst_ready", {60'd0, req_ready}, 64'd0);
    check("rst_grant", {62'd0, grant_id}, 64'd0);
    wrst        = 1'b0;
    cyc         = 0;
    last_wr_cyc = 0;
  endtask

  function automatic logic [7:0] log_at(input int k);
    if (k < wlog.size()) return wlog[k];
    else return 8'hxx;
  endfunction

  logic [7:0] exp2 [10] = '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32, 8'h03, 8'h04};
  logic [7:0] exp3 [12] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h20, 8'h21,
                            8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};

  initial begin
    // ---- single requester, 3-beat packet ----
    do_reset();
    add_beat(0, 8'h01, 1'b0);
    add_beat(0, 8'h02, 1'b0);
    add_beat(0, 8'h03, 1'b1);
    refresh();
    wtrace = 5'd0;
    btrace = 5'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      wtrace = {wtrace[3:0], win};
      btrace = {btrace[3:0], bsy};
    end
    check("s1_winc_trace", {59'd0, wtrace}, 64'b01110);
    check("s1_busy_trace", {59'd0, btrace}, 64'b01110);
    check("s1_log_size", 64'(wlog.size()), 64'd3);
    for (int k = 0; k < 3; k++) check("s1_data", {56'd0, log_at(k)}, 64'(k + 1));
    check("s1_grant", {62'd0, grant_id}, 64'd0);

    // ---- all four requesters, 2-beat packets, round robin ----
    do_reset();
    add_beat(0, 8'h01, 1'b0); add_beat(0, 8'h02, 1'b1);
    add_beat(0, 8'h03, 1'b0); add_beat(0, 8'h04, 1'b1);
    for (int r = 1; r < NREQ; r++) begin
      add_beat(r, 8'(r * 16 + 1), 1'b0);
      add_beat(r, 8'(r * 16 + 2), 1'b1);
    end
    refresh();
    for (int k = 0; k < 40 && wlog.size() < 10; k++) tick();
    check("s2_log_size", 64'(wlog.size()), 64'd10);
    for (int k = 0; k < 10; k++) check("s2_order", {56'd0, log_at(k)}, {56'd0, exp2[k]});
    check("s2_last_cycle", 64'(last_wr_cyc), 64'd15);

    // ---- long stream split at BURST_MAX, interleaved at burst boundaries ----
    do_reset();
    for (int b = 0; b < 10; b++) add_beat(1, 8'(8'h10 + b), 1'b0);
    add_beat(2, 8'h20, 1'b0);
    add_beat(2, 8'h21, 1'b1);
    refresh();
    for (int k = 0; k < 40 && wlog.size() < 12; k++) tick();
    check("s3_last_cycle", 64'(last_wr_cyc), 64'd16);
    for (int k = 0; k < 3; k++) tick();
    check("s3_log_size", 64'(wlog.size()), 64'd12);
    for (int k = 0; k < 12; k++) check("s3_order", {56'd0, log_at(k)}, {56'd0, exp3[k]});
    check("s3_hold_busy", {63'd0, busy}, 64'd1);
    check("s3_hold_grant", {62'd0, grant_id}, 64'd1);

    // ---- FIFO full for 5 cycles after beat 2 ----
    do_reset();
    add_beat(0, 8'h01, 1'b0); add_beat(0, 8'h02, 1'b0);
    add_beat(0, 8'h03, 1'b0); add_beat(0, 8'h04, 1'b1);
    refresh();
    for (int k = 0; k < 3; k++) tick();
    check("s4_pre_size", 64'(wlog.size()), 64'd2);
    fifo_wfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("s4_stall_winc", {63'd0, win}, 64'd0);
      check("s4_stall_ready", {60'd0, rdy}, 64'd0);
      check("s4_stall_busy", {63'd0, bsy}, 64'd1);
    end
    check("s4_stall_grant", {62'd0, grant_id}, 64'd0);
    fifo_wfull = 1'b0;
    tick();
    check("s4_resume_winc", {63'd0, win}, 64'd1);
    check("s4_resume_data", {56'd0, wd}, 64'h03);
    tick();
    check("s4_beat4_data", {56'd0, wd}, 64'h04);
    check("s4_log_size", 64'(wlog.size()), 64'd4);
`ifdef FIFO_WR_ARB_STATS_EN
    check("s4_stat_stall", {32'd0, stat_stall}, 64'd5);
    check("s4_stat_beats0", {32'd0, stat_beats[31:0]}, 64'd4);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("s4_clr_stall", {32'd0, stat_stall}, 64'd0);
    check("s4_clr_beats", {stat_beats[63:32] | stat_beats[127:96], stat_beats[31:0] | stat_beats[95:64]}, 64'd0);
`endif

    // ---- async reset mid-burst, then priority returns to requester 0 ----
    do_reset();
    for (int b = 1; b <= 4; b++) add_beat(2, 8'(8'h20 + b), (b == 4) ? 1'b1 : 1'b0);
    refresh();
    for (int k = 0; k < 3; k++) tick();
    check("s5_pre_grant", {62'd0, grant_id}, 64'd2);
    check("s5_pre_size", 64'(wlog.size()), 64'd2);
    wrst = 1'b1;
    #1;
    check("s5_rst_busy", {63'd0, busy}, 64'd0);
    check("s5_rst_winc", {63'd0, fifo_winc}, 64'd0);
    check("s5_rst_ready", {60'd0, req_ready}, 64'd0);
    add_beat(0, 8'h01, 1'b1);
    refresh();
    @(posedge wclk);
    #1;
    wrst = 1'b0;
    tick();
    check("s5_new_grant", {62'd0, grant_id}, 64'd0);
    check("s5_new_ready", {60'd0, req_ready}, 64'b0001);
    tick();
    check("s5_new_winc", {63'd0, win}, 64'd1);
    check("s5_new_data", {56'd0, wd}, 64'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
